// File: rtl/tcp_test_xg.sv
// ---------------------------------------------------------------------------
// tcp_test_xg
//
// Test-traffic generator and receive checker for the SiTCP/SiTCPXG user data
// path. This is the multi-byte-lane version of the 8-bit tcp_test block.
//
// Generator: writes a deterministic byte stream into the TCP transmit
// interface at a programmable rate, for a programmable byte count.
// Checker:   compares the received stream against the same sequence and
//            counts the bytes that do not match.
// Also provides a registered RX->TX loopback and a one-shot error injector.
//
// Stream byte k:
//   SELECT_SEQ = 0 : SEQ_PATTERN[7:0] + k (mod 256)
//   SELECT_SEQ = 1 : byte (k mod 4) of SEQ_PATTERN, byte 0 = bits [7:0]
//
// Parameters
//   BYTES  data bus width in bytes (1..8), lane i = bits [8i+7:8i]
//   ERR_W  width of RX_ERR_CNT
//
// Ports
//   CLK, RST_N     clock, asynchronous active-low reset
//   TX_RATE        idle cycles inserted after each issued beat
//   NUM_OF_DATA    bytes per run, 0 = unlimited
//   DATA_GEN       run request (level, a run starts on its rising edge)
//   LOOPBACK       1 = TX carries registered RX, generator held idle
//   SELECT_SEQ     stream type select
//   SEQ_PATTERN    seed (incrementing mode) or 32-bit repeating pattern
//   INS_ERROR      pulse, flips lane 0 bit 0 of the next generated beat
//   TCP_OPEN       connection established
//   TCP_RX_*       receive beat from the TCP core
//   TCP_TX_FULL    transmit almost-full from the TCP core
//   TCP_TX_*       transmit beat to the TCP core (registered)
//   TX_BYTE_CNT    bytes sent in the current or last run
//   RX_BYTE_CNT    bytes received since TCP_OPEN rose
//   RX_ERR_CNT     mismatched received bytes, saturating
//   BUSY, DONE     generator in RUN / in DONE
// ---------------------------------------------------------------------------
module tcp_test_xg #(
    parameter int BYTES = 8,
    parameter int ERR_W = 32
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [7:0]           TX_RATE,
    input  logic [63:0]          NUM_OF_DATA,
    input  logic                 DATA_GEN,
    input  logic                 LOOPBACK,
    input  logic                 SELECT_SEQ,
    input  logic [31:0]          SEQ_PATTERN,
    input  logic                 INS_ERROR,
    input  logic                 TCP_OPEN,
    input  logic                 TCP_RX_WR,
    input  logic [BYTES-1:0]     TCP_RX_BE,
    input  logic [8*BYTES-1:0]   TCP_RX_DATA,
    input  logic                 TCP_TX_FULL,
    output logic                 TCP_TX_WR,
    output logic [BYTES-1:0]     TCP_TX_BE,
    output logic [8*BYTES-1:0]   TCP_TX_DATA,
    output logic [63:0]          TX_BYTE_CNT,
    output logic [63:0]          RX_BYTE_CNT,
    output logic [ERR_W-1:0]     RX_ERR_CNT,
    output logic                 BUSY,
    output logic                 DONE
);

    // Generator states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Lane counts go up to BYTES (max 8), so 4 bits hold them
    localparam int            LW      = 4;
    localparam logic [LW-1:0] LANES   = LW'(BYTES);
    localparam logic [63:0]   LANES64 = 64'(BYTES);

    // Expected stream byte for a given index. Only the low 8 bits of the
    // index matter: mode 0 wraps mod 256 and mode 1 repeats every 4 bytes.
    function automatic logic [7:0] seqByte(input logic        sel,
                                           input logic [31:0] pat,
                                           input logic [7:0]  idx);
        logic [7:0] patByte;
        case (idx[1:0])
            2'd0:    patByte = pat[7:0];
            2'd1:    patByte = pat[15:8];
            2'd2:    patByte = pat[23:16];
            default: patByte = pat[31:24];
        endcase
        return sel ? patByte : (pat[7:0] + idx);
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [1:0]           state_q,     state_d;
    logic [63:0]          txByteCnt_q, txByteCnt_d;
    logic [7:0]           rateCnt_q,   rateCnt_d;
    logic                 errPend_q,   errPend_d;
    logic                 dataGenPrev_q;
    logic                 openPrev_q;
    logic                 txWr_q,      txWr_d;
    logic [BYTES-1:0]     txBe_q,      txBe_d;
    logic [8*BYTES-1:0]   txData_q,    txData_d;
    logic [63:0]          rxByteCnt_q, rxByteCnt_d;
    logic [ERR_W-1:0]     rxErrCnt_q,  rxErrCnt_d;

    // -----------------------------------------------------------------------
    // Generator decode
    // -----------------------------------------------------------------------
    logic [63:0]          remaining;
    logic                 unlimited;
    logic                 noneLeft;
    logic [LW-1:0]        beatLen;
    logic                 lastBeat;
    logic                 dataGenRise;
    logic                 runAbort;
    logic                 issue;
    logic [BYTES-1:0]     genBe;
    logic [8*BYTES-1:0]   genData;

    // The tx stream index and TX_BYTE_CNT clear together and always advance
    // by the same amount, so the byte counter doubles as the stream index.
    assign remaining   = NUM_OF_DATA - txByteCnt_q;
    assign unlimited   = (NUM_OF_DATA == 64'd0);
    // Covers NUM_OF_DATA being lowered below the count already sent mid-run
    assign noneLeft    = !unlimited && (NUM_OF_DATA <= txByteCnt_q);
    assign beatLen     = (unlimited || (remaining >= LANES64)) ? LANES : remaining[LW-1:0];
    assign lastBeat    = !unlimited && (remaining == 64'(beatLen));
    assign dataGenRise = DATA_GEN && !dataGenPrev_q;
    assign runAbort    = !DATA_GEN || !TCP_OPEN || LOOPBACK;

    // An abort wins over issuing, so no partial beat leaks out on the way
    // back to IDLE.
    assign issue = (state_q == ST_RUN) && !runAbort && !noneLeft &&
                   (rateCnt_q == 8'd0) && !TCP_TX_FULL;

    // Lanes 0..beatLen-1 carry consecutive stream bytes; unused lanes are
    // zero. A pending injected error flips bit 0 of lane 0 only, so exactly
    // one byte of the stream is corrupted.
    always_comb begin
        genBe   = '0;
        genData = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (LW'(i) < beatLen) begin
                genBe[i]          = 1'b1;
                genData[8*i +: 8] = seqByte(SELECT_SEQ, SEQ_PATTERN,
                                            txByteCnt_q[7:0] + 8'(i));
            end
        end
        genData[0] = genData[0] ^ errPend_q;
    end

    // Generator FSM. The rate counter free-runs down to zero whenever it is
    // loaded, including while TCP_TX_FULL stalls the stream, so a stall does
    // not add extra spacing on top of the programmed rate.
    always_comb begin
        state_d     = state_q;
        txByteCnt_d = txByteCnt_q;
        rateCnt_d   = (rateCnt_q != 8'd0) ? (rateCnt_q - 8'd1) : 8'd0;
        errPend_d   = errPend_q || INS_ERROR;

        case (state_q)
            ST_IDLE: begin
                if (dataGenRise && TCP_OPEN && !LOOPBACK) begin
                    state_d     = ST_RUN;
                    txByteCnt_d = 64'd0;
                    rateCnt_d   = 8'd0;
                end
            end
            ST_RUN: begin
                if (runAbort) begin
                    state_d   = ST_IDLE;
                    errPend_d = 1'b0;
                end else if (noneLeft) begin
                    state_d = ST_DONE;
                end else if (issue) begin
                    txByteCnt_d = txByteCnt_q + 64'(beatLen);
                    rateCnt_d   = TX_RATE;
                    // A pulse arriving on the issuing cycle is kept for the
                    // following beat rather than lost.
                    errPend_d   = INS_ERROR;
                    if (lastBeat) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (!DATA_GEN) begin
                    state_d   = ST_IDLE;
                    errPend_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Transmit output select. Loopback bypasses the generator entirely and
    // ignores TCP_TX_FULL; the generator is held in IDLE by runAbort then.
    always_comb begin
        if (LOOPBACK) begin
            txWr_d   = TCP_RX_WR;
            txBe_d   = TCP_RX_BE;
            txData_d = TCP_RX_DATA;
        end else begin
            txWr_d   = issue;
            txBe_d   = issue ? genBe   : '0;
            txData_d = issue ? genData : '0;
        end
    end

    // -----------------------------------------------------------------------
    // Receive checker
    // -----------------------------------------------------------------------
    logic                 openRise;
    logic [63:0]          rxBase;
    logic [ERR_W-1:0]     errBase;
    logic [LW-1:0]        rxTaken;
    logic [LW-1:0]        rxMiss;
    logic [ERR_W:0]       errSum;

    assign openRise = TCP_OPEN && !openPrev_q;

    // Enabled lanes are packed onto consecutive stream indices in ascending
    // lane order, so a sparse BE still checks a contiguous run of the stream.
    // A beat arriving on the same cycle TCP_OPEN rises is checked against a
    // freshly cleared index. As with TX, the rx index is RX_BYTE_CNT itself.
    always_comb begin
        rxBase  = openRise ? 64'd0 : rxByteCnt_q;
        errBase = openRise ? '0    : rxErrCnt_q;
        rxTaken = '0;
        rxMiss  = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (TCP_RX_WR && TCP_RX_BE[i]) begin
                if (TCP_RX_DATA[8*i +: 8] !=
                    seqByte(SELECT_SEQ, SEQ_PATTERN, rxBase[7:0] + 8'(rxTaken))) begin
                    rxMiss = rxMiss + LW'(1);
                end
                rxTaken = rxTaken + LW'(1);
            end
        end
        rxByteCnt_d = rxBase + 64'(rxTaken);
        // One extra bit catches the carry; on overflow the count pins at
        // all-ones instead of wrapping.
        errSum      = {1'b0, errBase} + (ERR_W+1)'(rxMiss);
        rxErrCnt_d  = errSum[ERR_W] ? '1 : errSum[ERR_W-1:0];
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= ST_IDLE;
            txByteCnt_q   <= 64'd0;
            rateCnt_q     <= 8'd0;
            errPend_q     <= 1'b0;
            dataGenPrev_q <= 1'b0;
            openPrev_q    <= 1'b0;
            txWr_q        <= 1'b0;
            txBe_q        <= '0;
            txData_q      <= '0;
            rxByteCnt_q   <= 64'd0;
            rxErrCnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            txByteCnt_q   <= txByteCnt_d;
            rateCnt_q     <= rateCnt_d;
            errPend_q     <= errPend_d;
            dataGenPrev_q <= DATA_GEN;
            openPrev_q    <= TCP_OPEN;
            txWr_q        <= txWr_d;
            txBe_q        <= txBe_d;
            txData_q      <= txData_d;
            rxByteCnt_q   <= rxByteCnt_d;
            rxErrCnt_q    <= rxErrCnt_d;
        end
    end

    assign TCP_TX_WR   = txWr_q;
    assign TCP_TX_BE   = txBe_q;
    assign TCP_TX_DATA = txData_q;
    assign TX_BYTE_CNT = txByteCnt_q;
    assign RX_BYTE_CNT = rxByteCnt_q;
    assign RX_ERR_CNT  = rxErrCnt_q;
    assign BUSY        = (state_q == ST_RUN);
    assign DONE        = (state_q == ST_DONE);

endmodule

// File: tb/tb_tcp_test_xg.sv
// ---------------------------------------------------------------------------
// tb_tcp_test_xg
//
// Self-checking bench for tcp_test_xg with BYTES = 8. Expected transmit beats
// are queued when a run is started and compared as the DUT emits them.
// ---------------------------------------------------------------------------
module tb_tcp_test_xg;

    logic         clk;
    logic         rstN;
    logic [7:0]   txRate;
    logic [63:0]  numOfData;
    logic         dataGen;
    logic         loopback;
    logic         selectSeq;
    logic [31:0]  seqPattern;
    logic         insError;
    logic         tcpOpen;
    logic         txFull;
    logic         feedback;
    logic         rxWrDrv;
    logic [7:0]   rxBeDrv;
    logic [63:0]  rxDataDrv;

    logic         rxWr;
    logic [7:0]   rxBe;
    logic [63:0]  rxData;
    logic         txWr;
    logic [7:0]   txBe;
    logic [63:0]  txData;
    logic [63:0]  txByteCnt;
    logic [63:0]  rxByteCnt;
    logic [31:0]  rxErrCnt;
    logic         busy;
    logic         done;

    int           testsRun;
    int           testsFailed;
    int           cycle;
    logic [71:0]  expQ[$];
    int           beatStamps[$];

    // External TX->RX wiring for the checker tests
    assign rxWr   = feedback ? txWr   : rxWrDrv;
    assign rxBe   = feedback ? txBe   : rxBeDrv;
    assign rxData = feedback ? txData : rxDataDrv;

    tcp_test_xg #(.BYTES(8), .ERR_W(32)) dut (
        .CLK         (clk),
        .RST_N       (rstN),
        .TX_RATE     (txRate),
        .NUM_OF_DATA (numOfData),
        .DATA_GEN    (dataGen),
        .LOOPBACK    (loopback),
        .SELECT_SEQ  (selectSeq),
        .SEQ_PATTERN (seqPattern),
        .INS_ERROR   (insError),
        .TCP_OPEN    (tcpOpen),
        .TCP_RX_WR   (rxWr),
        .TCP_RX_BE   (rxBe),
        .TCP_RX_DATA (rxData),
        .TCP_TX_FULL (txFull),
        .TCP_TX_WR   (txWr),
        .TCP_TX_BE   (txBe),
        .TCP_TX_DATA (txData),
        .TX_BYTE_CNT (txByteCnt),
        .RX_BYTE_CNT (rxByteCnt),
        .RX_ERR_CNT  (rxErrCnt),
        .BUSY        (busy),
        .DONE        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [127:0] actual,
                               input logic [127:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Reference stream byte k
    function automatic logic [7:0] expByte(input logic sel, input logic [31:0] pat,
                                           input int k);
        logic [7:0] b;
        if (sel) begin
            case (k & 3)
                0:       b = pat[7:0];
                1:       b = pat[15:8];
                2:       b = pat[23:16];
                default: b = pat[31:24];
            endcase
        end else begin
            b = pat[7:0] + 8'(k);
        end
        return b;
    endfunction

    // Queue the beats of a num-byte run; beat number errBeat gets bit 0 flipped
    task automatic pushRun(input int num, input logic sel, input logic [31:0] pat,
                           input int errBeat);
        int k;
        int b;
        int n;
        logic [7:0]  be;
        logic [63:0] data;
        k = 0;
        b = 0;
        while (k < num) begin
            n    = (num - k > 8) ? 8 : (num - k);
            be   = 8'((16'd1 << n) - 16'd1);
            data = '0;
            for (int i = 0; i < n; i++) data[8*i +: 8] = expByte(sel, pat, k + i);
            if (b == errBeat) data[0] = ~data[0];
            expQ.push_back({be, data});
            k += n;
            b++;
        end
    endtask

    // Scoreboard consumer: every emitted beat must match the head of the queue
    always @(negedge clk) begin
        if (rstN && txWr) begin
            beatStamps.push_back(cycle);
            if (expQ.size() == 0) begin
                checkOutput("unexpectedBeat", 128'(expQ.size()), 128'd1);
            end else begin
                checkOutput("beat", 128'({txBe, txData}), 128'(expQ.pop_front()));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input int num, input logic [7:0] rate,
                                 input logic sel, input logic [31:0] pat);
        numOfData  = 64'(num);
        txRate     = rate;
        selectSeq  = sel;
        seqPattern = pat;
        beatStamps.delete();
        dataGen    = 1'b1;
    endtask

    task automatic waitDone(input string tag, input int budget);
        int c;
        c = 0;
        while (!done && c < budget) begin
            tick(1);
            c++;
        end
        checkOutput(tag, 128'(done), 128'd1);
        tick(2);
    endtask

    task automatic stopRun();
        dataGen = 1'b0;
        tick(2);
    endtask

    task automatic reopen();
        tcpOpen = 1'b0;
        tick(1);
        tcpOpen = 1'b1;
        tick(1);
    endtask

    function automatic int badSpacing(input int gap);
        int bad;
        bad = 0;
        for (int i = 1; i < beatStamps.size(); i++)
            if (beatStamps[i] - beatStamps[i-1] != gap) bad++;
        return bad;
    endfunction

    function automatic int countAfter(input int lo, input int hi);
        int c;
        c = 0;
        foreach (beatStamps[i])
            if (beatStamps[i] > lo && beatStamps[i] <= hi) c++;
        return c;
    endfunction

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cycle);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int c0;
        int cf;
        testsRun    = 0;
        testsFailed = 0;
        cycle       = 0;
        rstN        = 1'b0;
        txRate      = 8'd0;
        numOfData   = 64'd0;
        dataGen     = 1'b0;
        loopback    = 1'b0;
        selectSeq   = 1'b0;
        seqPattern  = 32'd0;
        insError    = 1'b0;
        tcpOpen     = 1'b0;
        txFull      = 1'b0;
        feedback    = 1'b0;
        rxWrDrv     = 1'b0;
        rxBeDrv     = 8'd0;
        rxDataDrv   = 64'd0;

        // Reset state
        tick(3);
        checkOutput("rstTxWr",   128'({txWr, txBe, txData}), 128'd0);
        checkOutput("rstTxCnt",  128'(txByteCnt), 128'd0);
        checkOutput("rstRxCnt",  128'(rxByteCnt), 128'd0);
        checkOutput("rstErrCnt", 128'(rxErrCnt), 128'd0);
        checkOutput("rstStatus", 128'({busy, done}), 128'd0);
        rstN = 1'b1;
        tick(2);
        tcpOpen  = 1'b1;
        feedback = 1'b1;
        tick(2);

        // 20-byte run, back-to-back beats, looped into the checker
        pushRun(20, 1'b0, 32'd0, -1);
        c0 = cycle;
        applyStimulus(20, 8'd0, 1'b0, 32'd0);
        waitDone("aDone", 50);
        checkOutput("aBeats",     128'(beatStamps.size()), 128'd3);
        checkOutput("aLatency",   128'((beatStamps.size() > 0) ? beatStamps[0] - c0 : -1), 128'd2);
        checkOutput("aSpacing",   128'(badSpacing(1)), 128'd0);
        checkOutput("aTxCnt",     128'(txByteCnt), 128'd20);
        checkOutput("aRxCnt",     128'(rxByteCnt), 128'd20);
        checkOutput("aErrCnt",    128'(rxErrCnt), 128'd0);
        checkOutput("aDrained",   128'(expQ.size()), 128'd0);
        stopRun();
        checkOutput("aIdle",      128'({busy, done}), 128'd0);

        // Same stream with one injected error landing between beats 0 and 1
        reopen();
        pushRun(20, 1'b0, 32'd0, 1);
        c0 = cycle;
        applyStimulus(20, 8'd3, 1'b0, 32'd0);
        tick(3);
        insError = 1'b1;
        tick(1);
        insError = 1'b0;
        waitDone("eDone", 80);
        checkOutput("eSpacing",   128'(badSpacing(4)), 128'd0);
        checkOutput("eRxCnt",     128'(rxByteCnt), 128'd20);
        checkOutput("eErrCnt",    128'(rxErrCnt), 128'd1);
        checkOutput("eDrained",   128'(expQ.size()), 128'd0);
        stopRun();
        feedback = 1'b0;

        // 256 bytes at TX_RATE=5: 32 beats, 6 cycles apart
        pushRun(256, 1'b0, 32'd0, -1);
        applyStimulus(256, 8'd5, 1'b0, 32'd0);
        waitDone("bDone", 400);
        checkOutput("bBeats",     128'(beatStamps.size()), 128'd32);
        checkOutput("bSpacing",   128'(badSpacing(6)), 128'd0);
        checkOutput("bTxCnt",     128'(txByteCnt), 128'd256);
        stopRun();

        // Same run with TCP_TX_FULL held for 20 cycles mid-run
        pushRun(256, 1'b0, 32'd0, -1);
        applyStimulus(256, 8'd5, 1'b0, 32'd0);
        tick(30);
        txFull = 1'b1;
        cf     = cycle;
        tick(20);
        txFull = 1'b0;
        waitDone("fDone", 500);
        checkOutput("fLateBeats", 128'(countAfter(cf, cf + 20) <= 1), 128'd1);
        checkOutput("fBeats",     128'(beatStamps.size()), 128'd32);
        checkOutput("fDrained",   128'(expQ.size()), 128'd0);
        stopRun();

        // Repeating 32-bit pattern, single 8-byte beat
        expQ.push_back({8'hFF, 64'h6080_8040_6080_8040});
        applyStimulus(8, 8'd0, 1'b1, 32'h6080_8040);
        waitDone("pDone", 20);
        checkOutput("pBeats",     128'(beatStamps.size()), 128'd1);
        checkOutput("pDrained",   128'(expQ.size()), 128'd0);
        stopRun();

        // Single-lane RX beats: only lane 0 is checked
        selectSeq  = 1'b0;
        seqPattern = 32'd0;
        reopen();
        for (int j = 0; j < 20; j++) begin
            rxWrDrv   = 1'b1;
            rxBeDrv   = 8'h01;
            rxDataDrv = {56'hAA_AAAA_AAAA_AAAA, 8'(j)};
            tick(1);
        end
        rxWrDrv = 1'b0;
        rxBeDrv = 8'h00;
        tick(2);
        checkOutput("sRxCnt",     128'(rxByteCnt), 128'd20);
        checkOutput("sErrCnt",    128'(rxErrCnt), 128'd0);

        // Loopback: RX beat reappears on TX one cycle later, generator idle
        loopback = 1'b1;
        dataGen  = 1'b1;
        beatStamps.delete();
        expQ.push_back({8'h3F, 64'h0000_0605_0403_0201});
        rxWrDrv   = 1'b1;
        rxBeDrv   = 8'h3F;
        rxDataDrv = 64'h0000_0605_0403_0201;
        c0 = cycle;
        tick(1);
        rxWrDrv   = 1'b0;
        rxBeDrv   = 8'h00;
        rxDataDrv = 64'd0;
        tick(3);
        checkOutput("lLatency",   128'((beatStamps.size() > 0) ? beatStamps[0] - c0 : -1), 128'd1);
        checkOutput("lBeats",     128'(beatStamps.size()), 128'd1);
        checkOutput("lBusy",      128'(busy), 128'd0);
        checkOutput("lDrained",   128'(expQ.size()), 128'd0);
        dataGen = 1'b0;
        tick(1);
        loopback = 1'b0;
        tick(2);

        // Abort an unlimited run by dropping DATA_GEN
        pushRun(240, 1'b0, 32'd0, -1);
        applyStimulus(0, 8'd2, 1'b0, 32'd0);
        tick(12);
        dataGen = 1'b0;
        cf      = cycle;
        tick(6);
        checkOutput("xLateBeats", 128'(countAfter(cf, cf + 6) <= 1), 128'd1);
        checkOutput("xIdle",      128'({busy, done}), 128'd0);
        checkOutput("xTxCnt",     128'(txByteCnt), 128'(8 * beatStamps.size()));
        expQ.delete();

        // Asynchronous reset in the middle of a run, then a clean restart
        pushRun(240, 1'b0, 32'd0, -1);
        applyStimulus(0, 8'd0, 1'b0, 32'd0);
        tick(5);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("arTxOut",    128'({txWr, txBe, txData}), 128'd0);
        checkOutput("arCounts",   128'({txByteCnt, rxByteCnt}), 128'd0);
        checkOutput("arStatus",   128'({busy, done, rxErrCnt}), 128'd0);
        dataGen = 1'b0;
        tick(2);
        expQ.delete();
        rstN = 1'b1;
        tick(2);
        pushRun(16, 1'b0, 32'd0, -1);
        applyStimulus(16, 8'd0, 1'b0, 32'd0);
        waitDone("rDone", 40);
        checkOutput("rTxCnt",     128'(txByteCnt), 128'd16);
        checkOutput("rDrained",   128'(expQ.size()), 128'd0);
        stopRun();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/tcp_test_xg.md
# tcp_test_xg

Parametrised TCP test-traffic generator and receive checker for the SiTCP/SiTCPXG data path, the multi-byte-lane successor of the 8-bit `tcp_test` block. It sits directly on the user side of the TCP core and drives the transmit write interface with a deterministic byte stream, at a programmable rate, for a programmable byte count. It checks the received byte stream against the same sequence and counts mismatches. It also provides a registered loopback mode and a one-shot error-injection input.

## Interface
Parameters:
- `BYTES`, 8: data bus width in bytes (1..8); lane i = bits [8i+7:8i].
- `ERR_W`, 32: width of `RX_ERR_CNT`.

Ports:
- `CLK`  in  1  system clock (156.25 MHz in the XG design).
- `RST_N`  in  1  asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- `TX_RATE`  in  8  number of idle cycles inserted after each issued beat.
- `NUM_OF_DATA`  in  64  bytes per run; 0 = unlimited.
- `DATA_GEN`  in  1  run request, level.
- `LOOPBACK`  in  1  1 = forward RX to TX and disable the generator.
- `SELECT_SEQ`  in  1  0 = incrementing bytes; 1 = repeating 32-bit pattern.
- `SEQ_PATTERN`  in  32  seed (mode 0, bits [7:0]) or pattern (mode 1).
- `INS_ERROR`  in  1  pulse; corrupts the next transmitted beat.
- `TCP_OPEN`  in  1  TCP connection established.
- `TCP_RX_WR`  in  1  RX beat valid.
- `TCP_RX_BE`  in  BYTES  RX byte enables.
- `TCP_RX_DATA`  in  8*BYTES  RX data.
- `TCP_TX_FULL`  in  1  TX almost-full.
- `TCP_TX_WR`  out  1  TX beat valid.
- `TCP_TX_BE`  out  BYTES  TX byte enables.
- `TCP_TX_DATA`  out  8*BYTES  TX data.
- `TX_BYTE_CNT`  out  64  bytes sent in the current or last run.
- `RX_BYTE_CNT`  out  64  bytes received since `TCP_OPEN` rose.
- `RX_ERR_CNT`  out  ERR_W  mismatched RX bytes, saturating.
- `BUSY`  out  1  generator in RUN.
- `DONE`  out  1  generator in DONE.

## Operation
- Stream definition: byte k of the stream is d(k).
  - `SELECT_SEQ`=0: d(k) = (`SEQ_PATTERN[7:0]` + k) mod 256.
  - `SELECT_SEQ`=1: d(k) = `SEQ_PATTERN` byte (k mod 4), with byte 0 = bits [7:0].
- Generator FSM states are IDLE, RUN and DONE.
  - IDLE -> RUN on a rising edge of `DATA_GEN` when `TCP_OPEN`=1 and `LOOPBACK`=0. On this transition, tx index k, `TX_BYTE_CNT` and the rate counter clear to 0.
  - In RUN, a beat issues on a cycle when all of these hold: the rate counter is 0, `TCP_TX_FULL`=0 and `TCP_OPEN`=1.
  - Each beat carries n = min(`BYTES`, remaining) bytes on lanes 0..n-1 with d(k)..d(k+n-1), and BE = low n bits set. After the beat, k and `TX_BYTE_CNT` both advance by n, and the rate counter loads `TX_RATE`.
  - The rate counter decrements each cycle while nonzero. It keeps decrementing while `TCP_TX_FULL` is high.
  - RUN -> DONE when remaining reaches 0 (never when `NUM_OF_DATA`=0).
  - RUN -> IDLE on `DATA_GEN`=0, `TCP_OPEN`=0 or `LOOPBACK`=1. This is an abort: no partial beat is issued and `TX_BYTE_CNT` holds its value.
  - DONE -> IDLE when `DATA_GEN`=0.
- Error injection:
  - An `INS_ERROR` pulse sets a pending flag. Multiple pulses before the next beat merge into one.
  - The next issued beat has lane 0 bit 0 inverted; the flag clears on that beat.
  - k still advances normally, so exactly 1 byte is corrupted.
  - The flag clears when the FSM returns to IDLE.
- Loopback (`LOOPBACK`=1):
  - `TCP_TX_WR`/BE/DATA are the registered copies of `TCP_RX_WR`/BE/DATA.
  - `TCP_TX_FULL` is ignored; flow control is the host's responsibility.
  - The generator FSM is held in IDLE.
- Checker, active in all modes:
  - A rising edge of `TCP_OPEN` clears the rx index, `RX_BYTE_CNT` and `RX_ERR_CNT`.
  - On each `TCP_RX_WR` beat, the set BE lanes, in ascending lane order, are compared against d(j), d(j+1), ..., where j is the rx index.
  - `RX_ERR_CNT` increases by the number of mismatched bytes and saturates at all-ones.
  - The rx index and `RX_BYTE_CNT` both advance by popcount(BE).
  - A beat with BE=0 has no effect.
- Width rules: `TX_BYTE_CNT` and `RX_BYTE_CNT` wrap modulo 2^64. The byte index used for pattern selection is k mod 4.

## Timing
- Reset values: all outputs 0, FSM in IDLE, pending error flag 0, rate counter 0.
- Issue decision is made in cycle t, using `TCP_TX_FULL` sampled in cycle t. `TCP_TX_WR` is asserted registered in cycle t+1. `TX_BYTE_CNT`, `BUSY` and `DONE` are also registered.
- One late beat after `TCP_TX_FULL` rises is permitted, because the TCP core's full signal is an almost-full.
- First beat appears 2 cycles after the `DATA_GEN` rising edge is sampled. Cycle 1 is the IDLE->RUN transition, cycle 2 is the decision, and the beat is registered out the cycle after.
- Beat spacing is `TX_RATE`+1 cycles when not stalled.
- Loopback latency is 1 cycle.
- Counters update 1 cycle after the RX beat.
- Asserting `RST_N` low mid-run forces all outputs to 0 immediately, asynchronously.

## Test plan
- `BYTES`=8, `SELECT_SEQ`=0, seed 0, `NUM_OF_DATA`=20, `TX_RATE`=0 -> 3 consecutive beats: BE FF/FF/0F, bytes 0x00..0x13. Then `DONE`=1 and `TX_BYTE_CNT`=20.
- Same setup with `TX_RATE`=5, `NUM_OF_DATA`=256 -> 32 beats spaced exactly 6 cycles apart. Hold `TCP_TX_FULL`=1 for 20 cycles mid-run -> at most 1 beat issues after the rise, with no byte skipped or repeated.
- `SELECT_SEQ`=1, `SEQ_PATTERN`=0x60808040, `NUM_OF_DATA`=8 -> one beat, bytes 40 80 80 60 40 80 80 60.
- Feed TX into RX externally, pulse `INS_ERROR` once during the 20-byte run -> `RX_BYTE_CNT`=20 and `RX_ERR_CNT`=1. RX beats with BE=0x01 repeated 20 times -> `RX_ERR_CNT` stays 0.
- `LOOPBACK`=1, RX beat BE=0x3F with data 0x0102..06 -> identical TX beat 1 cycle later, and `BUSY` stays 0.
- Drop `DATA_GEN` mid-run -> `TCP_TX_WR` ends after at most 1 beat, and the FSM is in IDLE. Assert `RST_N` low mid-run -> all outputs 0 in the same cycle; a restart reproduces the stream from byte 0.
